// File: rtl/pm_spm_pkg.sv
// pm_spm_pkg
// Types shared by the program-memory self-programming (SPM) sequencer:
// SPM command encodings and sequencer state encoding.
package pm_spm_pkg;

  // SPM command field carried alongside spm_start_i.
  typedef enum logic [1:0] {
    SPM_NOP   = 2'b00,
    SPM_FILL  = 2'b01,
    SPM_ERASE = 2'b10,
    SPM_WRITE = 2'b11
  } spm_cmd_e;

  // Sequencer states. ST_VERIFY is only reachable when read-back verify
  // is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERASE  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } spm_state_e;

endpackage

// File: rtl/pm_page_buf.sv
// pm_page_buf
// One-page word buffer that collects SPM fill data before a page write.
// Contents are not reset: a page write always follows a complete set of
// fills in normal firmware use.
//
// Ports:
//   clk_i    system clock
//   we_i     write strobe (fill accepted)
//   widx_i   word index within the page for the write
//   wdata_i  fill data
//   ridx_i   word index for the combinational read port
//   rdata_o  buffer word at ridx_i
module pm_page_buf
  import pm_spm_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int PAGE_W    = 6
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [PAGE_W-1:0]    widx_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  logic [PAGE_W-1:0]    ridx_i,
  output logic [WORD_SIZE-1:0] rdata_o
);

  logic [WORD_SIZE-1:0] r_mem [1<<PAGE_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[ridx_i];

endmodule

// File: rtl/pm_spm_ctrl.sv
// pm_spm_ctrl
// Self-programming sequencer for the AVR program memory. Collects one page
// of fill words, then erases or writes a whole PM page while stalling the
// CPU. In IDLE the PM address follows the CPU fetch address.
//
// Optional build macro: PM_SPM_VERIFY_EN
//   When defined, every page write is followed by a read-back pass over the
//   page; a mismatch sets the sticky spm_err_o until the next accepted
//   erase/write command. When undefined, spm_err_o is constant 0.
//
// Ports:
//   clk_i        system clock (PM shares this edge)
//   rst_n_i      asynchronous reset, active low
//   cpu_addr_i   CPU fetch address
//   spm_start_i  one-cycle command strobe
//   spm_cmd_i    00 nop, 01 fill, 10 page erase, 11 page write
//   spm_addr_i   word address (low PAGE_W bits: fill index; high: page)
//   spm_data_i   fill data
//   pm_rdata_i   PM read data, one cycle after the address
//   pm_addr_o    PM address
//   pm_we_o      PM write enable
//   pm_wdata_o   PM write data
//   cpu_stall_o  CPU hold during a page operation
//   spm_busy_o   page operation in progress
//   spm_done_o   one-cycle pulse at the end of a page operation
//   spm_err_o    sticky verify mismatch flag
module pm_spm_ctrl
  import pm_spm_pkg::*;
#(
  parameter int                   WORD_SIZE = 16,
  parameter int                   ADDR_W    = 13,
  parameter int                   PAGE_W    = 6,
  parameter logic [WORD_SIZE-1:0] ERASE_VAL = 16'hFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic                 spm_start_i,
  input  logic [1:0]           spm_cmd_i,
  input  logic [ADDR_W-1:0]    spm_addr_i,
  input  logic [WORD_SIZE-1:0] spm_data_i,
  input  logic [WORD_SIZE-1:0] pm_rdata_i,
  output logic [ADDR_W-1:0]    pm_addr_o,
  output logic                 pm_we_o,
  output logic [WORD_SIZE-1:0] pm_wdata_o,
  output logic                 cpu_stall_o,
  output logic                 spm_busy_o,
  output logic                 spm_done_o,
  output logic                 spm_err_o
);

  localparam int PAGE_WORDS = 1 << PAGE_W;
  localparam int PGN_W      = ADDR_W - PAGE_W;
  // One extra counter bit so the read-back pass can count PAGE_WORDS+1 cycles.
  localparam int CNT_W      = PAGE_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAGE_WORDS - 1);

  spm_state_e             r_state;
  spm_state_e             w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [PGN_W-1:0]       r_page;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_buf_we;
  logic [PAGE_W-1:0]      w_buf_ridx;
  logic [WORD_SIZE-1:0]   w_buf_rdata;
  logic [ADDR_W-1:0]      w_pg_addr;

  // Address of the current word inside the latched page; the low bits never
  // carry into the page number, so a page operation cannot wrap.
  assign w_pg_addr = {r_page, r_cnt[PAGE_W-1:0]};

  pm_page_buf #(
    .WORD_SIZE (WORD_SIZE),
    .PAGE_W    (PAGE_W)
  ) u_page_buf (
    .clk_i   (clk_i),
    .we_i    (w_buf_we),
    .widx_i  (spm_addr_i[PAGE_W-1:0]),
    .wdata_i (spm_data_i),
    .ridx_i  (w_buf_ridx),
    .rdata_o (w_buf_rdata)
  );

`ifdef PM_SPM_VERIFY_EN
  // During read-back the PM returns the word addressed one cycle earlier,
  // so the expected value is the buffer word one index behind the counter.
  assign w_buf_ridx = (r_state == ST_VERIFY) ? (r_cnt[PAGE_W-1:0] - PAGE_W'(1))
                                             : r_cnt[PAGE_W-1:0];
`else
  assign w_buf_ridx = r_cnt[PAGE_W-1:0];
`endif

  // Next state and PM-side outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_buf_we     = 1'b0;
    pm_addr_o    = cpu_addr_i;
    pm_we_o      = 1'b0;
    pm_wdata_o   = '0;
    spm_done_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spm_start_i) begin
          if (spm_cmd_i == SPM_FILL) begin
            w_buf_we = 1'b1;
          end else if (spm_cmd_i == SPM_ERASE) begin
            w_accept     = 1'b1;
            w_state_next = ST_ERASE;
          end else if (spm_cmd_i == SPM_WRITE) begin
            w_accept     = 1'b1;
            w_state_next = ST_WRITE;
          end
        end
      end
      ST_ERASE: begin
        pm_addr_o  = w_pg_addr;
        pm_we_o    = 1'b1;
        pm_wdata_o = ERASE_VAL;
        if (r_cnt == CNT_LAST) begin
          w_state_next = ST_DONE;
        end
      end
      ST_WRITE: begin
        pm_addr_o  = w_pg_addr;
        pm_we_o    = 1'b1;
        pm_wdata_o = w_buf_rdata;
        if (r_cnt == CNT_LAST) begin
`ifdef PM_SPM_VERIFY_EN
          w_state_next = ST_VERIFY;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
`ifdef PM_SPM_VERIFY_EN
      ST_VERIFY: begin
        pm_addr_o = w_pg_addr;
        if (r_cnt == CNT_W'(PAGE_WORDS)) begin
          w_state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        spm_done_o   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_page  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
      if (w_accept) begin
        r_page <= spm_addr_i[ADDR_W-1:PAGE_W];
        r_cnt  <= '0;
      end else if (r_state == ST_ERASE || r_state == ST_WRITE ||
                   r_state == ST_VERIFY) begin
        // Restart the count on every phase change (WRITE -> VERIFY).
        r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign cpu_stall_o = r_busy;
  assign spm_busy_o  = r_busy;

`ifdef PM_SPM_VERIFY_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (r_state == ST_VERIFY && r_cnt != '0 && pm_rdata_i != w_buf_rdata) begin
      r_err <= 1'b1;
    end
  end

  assign spm_err_o = r_err;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^pm_rdata_i;
  assign spm_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pm_spm_ctrl.sv
// tb_pm_spm_ctrl
// Directed plus randomized bench for pm_spm_ctrl. A program-memory model
// (registered address, one-cycle read latency, optional read corruption)
// is attached to the PM port; expected values come from a page-level
// reference model (fill buffer array and expected memory image).
module tb_pm_spm_ctrl;

  localparam int AW = 13;
  localparam int WS = 16;
  localparam int PW = 6;
  localparam int NW = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          spm_start = 1'b0;
  logic [1:0]    spm_cmd = 2'b00;
  logic [AW-1:0] spm_addr = '0;
  logic [WS-1:0] spm_data = '0;
  logic [WS-1:0] pm_rdata;
  logic [AW-1:0] pm_addr;
  logic          pm_we;
  logic [WS-1:0] pm_wdata;
  logic          cpu_stall;
  logic          spm_busy;
  logic          spm_done;
  logic          spm_err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [WS-1:0] ref_buf [NW];
  logic [WS-1:0] ref_mem [1<<AW];
  logic          ref_err = 1'b0;

  // PM model
  logic [WS-1:0] pm_mem [1<<AW];
  logic [AW-1:0] pm_raddr = '0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = 13'h0052;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pm_we) pm_mem[pm_addr] <= pm_wdata;
    pm_raddr <= pm_addr;
  end

  assign pm_rdata = pm_mem[pm_raddr] ^
                    ((corrupt_en && pm_raddr == corrupt_addr) ? 16'h0100 : 16'h0000);

  pm_spm_ctrl dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cpu_addr_i  (cpu_addr),
    .spm_start_i (spm_start),
    .spm_cmd_i   (spm_cmd),
    .spm_addr_i  (spm_addr),
    .spm_data_i  (spm_data),
    .pm_rdata_i  (pm_rdata),
    .pm_addr_o   (pm_addr),
    .pm_we_o     (pm_we),
    .pm_wdata_o  (pm_wdata),
    .cpu_stall_o (cpu_stall),
    .spm_busy_o  (spm_busy),
    .spm_done_o  (spm_done),
    .spm_err_o   (spm_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".addr"},  pm_addr, cpu_addr);
    chk({tag, ".we"},    pm_we, 1'b0);
    chk({tag, ".stall"}, cpu_stall, 1'b0);
    chk({tag, ".busy"},  spm_busy, 1'b0);
    chk({tag, ".done"},  spm_done, 1'b0);
    chk({tag, ".err"},   spm_err, ref_err);
  endtask

  task automatic chk_page(input string tag, input logic [6:0] pg);
    int diffs = 0;
    for (int k = 0; k < NW; k++) begin
      if (pm_mem[{pg, 6'(k)}] !== ref_mem[{pg, 6'(k)}]) diffs++;
    end
    chk(tag, diffs, 0);
  endtask

  task automatic fill(input int idx, input logic [WS-1:0] d);
    spm_start = 1'b1;
    spm_cmd   = 2'b01;
    spm_addr  = {7'($urandom), 6'(idx)};
    spm_data  = d;
    @(posedge clk); #1;
    spm_start = 1'b0;
    spm_cmd   = 2'b00;
    ref_buf[idx] = d;
    chk_idle("fill");
  endtask

  // Issue an erase (10) or write (11) and follow it cycle by cycle to the
  // done pulse. With inject set, a fill of index 5 is strobed mid-operation.
  task automatic run_op(input logic [1:0] cmd, input logic [AW-1:0] addr, input bit inject);
    logic [6:0] pg;
    bit is_wr;
    pg    = addr[12:6];
    is_wr = (cmd == 2'b11);
    spm_start = 1'b1;
    spm_cmd   = cmd;
    spm_addr  = addr;
    @(posedge clk); #1;
    spm_start = 1'b0;
    spm_cmd   = 2'b00;
    ref_err   = 1'b0;
    for (int k = 0; k < NW; k++) begin
      chk("op.busy",  spm_busy, 1'b1);
      chk("op.stall", cpu_stall, 1'b1);
      chk("op.we",    pm_we, 1'b1);
      chk("op.addr",  pm_addr, {pg, 6'(k)});
      chk("op.wdata", pm_wdata, is_wr ? ref_buf[k] : 16'hFFFF);
      chk("op.done",  spm_done, 1'b0);
      chk("op.err",   spm_err, 1'b0);
      if (inject && k == 8) begin
        spm_start = 1'b1;
        spm_cmd   = 2'b01;
        spm_addr  = 13'h0005;
        spm_data  = 16'hBEEF;
      end else begin
        spm_start = 1'b0;
        spm_cmd   = 2'b00;
      end
      @(posedge clk); #1;
    end
    spm_start = 1'b0;
    spm_cmd   = 2'b00;
`ifdef PM_SPM_VERIFY_EN
    if (is_wr) begin
      for (int k = 0; k <= NW; k++) begin
        chk("vfy.we",    pm_we, 1'b0);
        chk("vfy.addr",  pm_addr, {pg, 6'(k)});
        chk("vfy.stall", cpu_stall, 1'b1);
        chk("vfy.done",  spm_done, 1'b0);
        @(posedge clk); #1;
      end
      ref_err = corrupt_en && (corrupt_addr[12:6] == pg);
    end
`endif
    chk("done.pulse", spm_done, 1'b1);
    chk("done.we",    pm_we, 1'b0);
    chk("done.stall", cpu_stall, 1'b1);
    chk("done.busy",  spm_busy, 1'b1);
    chk("done.addr",  pm_addr, cpu_addr);
    chk("done.err",   spm_err, ref_err);
    for (int k = 0; k < NW; k++) begin
      ref_mem[{pg, 6'(k)}] = is_wr ? ref_buf[k] : 16'hFFFF;
    end
    @(posedge clk); #1;
    chk_idle("after_op");
    chk_page("page_contents", pg);
  endtask

  initial begin
    logic [6:0] rpg;
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i] = 16'h5A5A ^ 16'(i);
      pm_mem[i] <= 16'h5A5A ^ 16'(i);
    end

    // Reset state and IDLE pass-through
    cpu_addr = 13'h0123;
    #1;
    chk("rst.we",    pm_we, 1'b0);
    chk("rst.stall", cpu_stall, 1'b0);
    chk("rst.busy",  spm_busy, 1'b0);
    chk("rst.done",  spm_done, 1'b0);
    chk("rst.err",   spm_err, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("idle0");
    chk("idle0.addr0123", pm_addr, 13'h0123);

    // Full page fill then unaligned write of page 0x0040
    for (int i = 0; i < NW; i++) fill(i, 16'hA000 + 16'(i));
    run_op(2'b11, 13'h0047, 1'b0);

    // Last fill to an index wins
    fill(3, 16'h1111);
    fill(3, 16'h2222);

    // Erase of the top page: no wrap past 0x1FFF
    cpu_addr = 13'h0000;
    run_op(2'b10, 13'h1FC0, 1'b0);

    // Fill attempted mid-write is dropped; next write exposes buffer[5]
    cpu_addr = 13'h0456;
    run_op(2'b11, 13'h0A13, 1'b1);
    run_op(2'b11, 13'h0C80, 1'b0);

    // NOP strobe is ignored
    spm_start = 1'b1;
    spm_cmd   = 2'b00;
    @(posedge clk); #1;
    spm_start = 1'b0;
    chk_idle("nop");
    @(posedge clk); #1;
    chk_idle("nop2");

    // Randomized fills and page operations
    for (int it = 0; it < 5; it++) begin
      int nf;
      nf = $urandom_range(1, 16);
      for (int f = 0; f < nf; f++) fill($urandom_range(0, NW - 1), 16'($urandom));
      cpu_addr = 13'($urandom);
      run_op($urandom_range(0, 1) ? 2'b11 : 2'b10, 13'($urandom), 1'b0);
    end

    // Reset in the 10th cycle of a write
    rpg = 7'h33;
    spm_start = 1'b1;
    spm_cmd   = 2'b11;
    spm_addr  = {rpg, 6'h00};
    @(posedge clk); #1;
    spm_start = 1'b0;
    spm_cmd   = 2'b00;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
    end
    chk("rstmid.pre_we",   pm_we, 1'b1);
    chk("rstmid.pre_addr", pm_addr, {rpg, 6'd9});
    rst_n = 1'b0;
    #1;
    chk("rstmid.we",    pm_we, 1'b0);
    chk("rstmid.stall", cpu_stall, 1'b0);
    chk("rstmid.busy",  spm_busy, 1'b0);
    chk("rstmid.done",  spm_done, 1'b0);
    ref_err = 1'b0;
    chk("rstmid.err",   spm_err, 1'b0);
    for (int k = 0; k < 9; k++) ref_mem[{rpg, 6'(k)}] = ref_buf[k];
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("rstmid.release");
    chk_page("rstmid.partial_page", rpg);

`ifdef PM_SPM_VERIFY_EN
    // Corrupted read-back of word 0x0052 flags an error until the next write
    corrupt_en = 1'b1;
    run_op(2'b11, 13'h0040, 1'b0);
    chk("vfy.err_set", spm_err, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_idle("vfy.err_held");
    run_op(2'b11, 13'h0100, 1'b0);
    chk("vfy.err_clear", spm_err, 1'b0);
`endif

    // Whole memory image against the reference
    begin
      int diffs = 0;
      for (int i = 0; i < (1 << AW); i++) begin
        if (pm_mem[i] !== ref_mem[i]) diffs++;
      end
      chk("pm_image", diffs, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
